vga_timing_gen: RTL and testbench

Parametrised VGA raster timing generator for the clock-display datapath. It derives a pixel strobe from the system clock, runs horizontal and vertical counters, and emits HS/VS, pixel coordinates, an active-video flag and a frame-start pulse. It also captures the hours/minutes/seconds inputs into registers that drive the drawing logic. It replaces the fixed 640x480 timing buried in the display top and generalises resolution, porches, sync polarity and clock division.

---
 rtl/vga_timing_gen.sv | 165 ++++++++++++++++
 tb/tb_vga_timing_gen.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA raster timing generator. Divides CLK down to a pixel strobe,
// runs horizontal/vertical counters and produces registered HS/VS, an active
// video flag and a one-cycle frame-start pulse, all aligned with pix_x/pix_y.
// Also captures the hours/minutes/seconds time inputs for the drawing logic.
//
// Optional feature macro: VGA_TIME_LATCH_EN
//   defined   : time inputs are captured only at the start of vertical blanking
//               (the strobe edge loading pix_x=0, pix_y=V_ACTIVE), so the values
//               are frozen for the whole visible region.
//   undefined : time inputs are registered every CLK (one-cycle latency).
//
// Ports
//   CLK          in   system clock, rising edge
//   RST_BTN      in   asynchronous active-low reset
//   seconds      in   [5:0] time input, 0..59
//   minutes      in   [5:0] time input, 0..59
//   hours        in   [4:0] time input, 0..23
//   VGA_HS_O     out  horizontal sync (asserted level HS_POL)
//   VGA_VS_O     out  vertical sync (asserted level VS_POL)
//   pix_stb      out  one-CLK pixel enable, every CLK_DIV cycles
//   pix_x        out  [CW-1:0] horizontal counter, 0..H_TOTAL-1
//   pix_y        out  [CW-1:0] vertical counter, 0..V_TOTAL-1
//   active       out  pixel is inside the visible area
//   frame_start  out  one-CLK pulse after the edge that loads (0,0)
//   sec_q/min_q/hr_q out captured time, stored raw
//   time_err     out  last captured time was out of range
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 10
) (
  input  logic          CLK,
  input  logic          RST_BTN,
  input  logic [5:0]    seconds,
  input  logic [5:0]    minutes,
  input  logic [4:0]    hours,
  output logic          VGA_HS_O,
  output logic          VGA_VS_O,
  output logic          pix_stb,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          active,
  output logic          frame_start,
  output logic [5:0]    sec_q,
  output logic [5:0]    min_q,
  output logic [4:0]    hr_q,
  output logic          time_err
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CW-1:0]    X_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0]    Y_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0]    Y_BLANK  = CW'(V_ACTIVE);

  // Decode bounds held at 32 bits so an end bound equal to 2^CW still compares
  // correctly against the zero-extended counter.
  localparam logic [31:0] H_VIS    = 32'(H_ACTIVE);
  localparam logic [31:0] V_VIS    = 32'(V_ACTIVE);
  localparam logic [31:0] HS_START = 32'(H_ACTIVE + H_FP);
  localparam logic [31:0] HS_END   = 32'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_ACTIVE + V_FP);
  localparam logic [31:0] VS_END   = 32'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CW-1:0]    x_q, x_d;
  logic [CW-1:0]    y_q, y_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             active_q, active_d;
  logic             fs_q, fs_d;
  logic             stb;
  logic             err_d;
  logic             cap_en;

  assign stb = (div_q == DIV_LAST);

  // Next-state and decode. The sync/active/frame decodes look at the *next*
  // coordinates so the registered flags change on the same edge as pix_x/pix_y.
  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    div_d = stb ? '0 : div_q + 1'b1;
    x_d   = x_q + 1'b1;
    y_d   = y_q;
    if (x_q == X_LAST) begin
      x_d = '0;
      y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
    end

    hs_d     = ((32'(x_d) >= HS_START) && (32'(x_d) < HS_END)) ? HS_POL : ~HS_POL;
    vs_d     = ((32'(y_d) >= VS_START) && (32'(y_d) < VS_END)) ? VS_POL : ~VS_POL;
    active_d = (32'(x_d) < H_VIS) && (32'(y_d) < V_VIS);
    fs_d     = (x_d == '0) && (y_d == '0);

    err_d = (seconds > 6'd59) | (minutes > 6'd59) | (hours > 5'd23);

`ifdef VGA_TIME_LATCH_EN
    // Freeze the time at the top of vertical blanking so a frame never tears.
    cap_en = stb && (x_d == '0) && (y_d == Y_BLANK);
`else
    cap_en = 1'b1;
`endif
  end

  // Reset parks the counters on the last pixel so the first strobe edge lands
  // on (0,0) and every frame, including the first, starts with frame_start.
  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      div_q    <= '0;
      x_q      <= X_LAST;
      y_q      <= Y_LAST;
      hs_q     <= ~HS_POL;
      vs_q     <= ~VS_POL;
      active_q <= 1'b0;
      fs_q     <= 1'b0;
      sec_q    <= '0;
      min_q    <= '0;
      hr_q     <= '0;
      time_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      div_q <= div_d;
      // frame_start is a single-CLK pulse, so it clears on non-strobe edges.
      fs_q  <= stb & fs_d;
      if (stb) begin
        x_q      <= x_d;
        y_q      <= y_d;
        hs_q     <= hs_d;
        vs_q     <= vs_d;
        active_q <= active_d;
      end
      if (cap_en) begin
        sec_q    <= seconds;
        min_q    <= minutes;
        hr_q     <= hours;
        time_err <= err_d;
      end
    end
  end

  assign pix_stb     = stb;
  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign VGA_HS_O    = hs_q;
  assign VGA_VS_O    = vs_q;
  assign active      = active_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen. A small geometry keeps whole frames short; a second
// instance runs CLK_DIV=1 with an active-high HS. A timing model derived from
// the number of clock edges since reset release feeds a scoreboard queue.
module tb_vga_timing_gen;

  localparam int CD  = 2;
  localparam int HA  = 8,  HFP = 2, HSY = 3, HBP = 3, HT = HA + HFP + HSY + HBP;
  localparam int VA  = 6,  VFP = 1, VSY = 2, VBP = 1, VT = VA + VFP + VSY + VBP;
  localparam int CW  = 5;
  localparam int FRAME = HT * VT * CD;

  typedef struct packed {
    logic          hs, vs, stb, act, fs;
    logic [CW-1:0] x, y;
    logic [5:0]    sec, mn;
    logic [4:0]    hr;
    logic          terr;
  } obs_t;

  typedef struct {
    logic [5:0] sec, mn;
    logic [4:0] hr;
    logic       err;
  } tvec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] seconds = '0, minutes = '0;
  logic [4:0] hours = '0;
  logic [5:0] zero6 = '0;
  logic [4:0] zero5 = '0;

  logic a_hs, a_vs, a_stb, a_act, a_fs, a_err;
  logic [CW-1:0] a_x, a_y;
  logic [5:0] a_sec, a_min;
  logic [4:0] a_hr;
  logic b_hs, b_vs, b_stb, b_act, b_fs, b_err;
  logic [CW-1:0] b_x, b_y;
  logic [5:0] b_sec, b_min;
  logic [4:0] b_hr;

  obs_t got_a, got_b;
  assign got_a = {a_hs, a_vs, a_stb, a_act, a_fs, a_x, a_y, a_sec, a_min, a_hr, a_err};
  assign got_b = {b_hs, b_vs, b_stb, b_act, b_fs, b_x, b_y, b_sec, b_min, b_hr, b_err};

  always #5 clk = ~clk;

  vga_timing_gen #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(CW)
  ) dut (
    .CLK(clk), .RST_BTN(rst_n), .seconds(seconds), .minutes(minutes), .hours(hours),
    .VGA_HS_O(a_hs), .VGA_VS_O(a_vs), .pix_stb(a_stb), .pix_x(a_x), .pix_y(a_y),
    .active(a_act), .frame_start(a_fs), .sec_q(a_sec), .min_q(a_min), .hr_q(a_hr),
    .time_err(a_err)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(CW)
  ) dut_sweep (
    .CLK(clk), .RST_BTN(rst_n), .seconds(zero6), .minutes(zero6), .hours(zero5),
    .VGA_HS_O(b_hs), .VGA_VS_O(b_vs), .pix_stb(b_stb), .pix_x(b_x), .pix_y(b_y),
    .active(b_act), .frame_start(b_fs), .sec_q(b_sec), .min_q(b_min), .hr_q(b_hr),
    .time_err(b_err)
  );

  int checks = 0;
  int errors = 0;
  obs_t exp_a[$];
  obs_t exp_b[$];
  int c_a = 0, c_b = 0;
  logic [5:0] cap_sec = '0, cap_min = '0;
  logic [4:0] cap_hr = '0;
  logic       cap_err = 1'b0;
  tvec_t tv [8];

  // Expected raster state after c rising edges with reset released.
  function automatic obs_t model(int cd, bit hpol, int c);
    obs_t o;
    int p, q, x, y;
    o = '0;
    o.stb = ((c % cd) == cd - 1);
    p = c / cd;
    if (p == 0) begin
      o.x  = CW'(HT - 1);
      o.y  = CW'(VT - 1);
      o.hs = ~hpol;
      o.vs = 1'b1;
    end else begin
      q = p - 1;
      x = q % HT;
      y = (q / HT) % VT;
      o.x   = CW'(x);
      o.y   = CW'(y);
      o.hs  = (x >= HA + HFP && x < HA + HFP + HSY) ? hpol : ~hpol;
      o.vs  = !(y >= VA + VFP && y < VA + VFP + VSY);
      o.act = (x < HA) && (y < VA);
      o.fs  = (x == 0) && (y == 0) && ((c % cd) == 0);
    end
    return o;
  endfunction

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  task automatic check_obs(string name, obs_t got, obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got x=%0d y=%0d hs=%b vs=%b stb=%b act=%b fs=%b t=%0d:%0d:%0d err=%b expected x=%0d y=%0d hs=%b vs=%b stb=%b act=%b fs=%b t=%0d:%0d:%0d err=%b",
               name, $time, got.x, got.y, got.hs, got.vs, got.stb, got.act, got.fs,
               got.hr, got.mn, got.sec, got.terr, exp.x, exp.y, exp.hs, exp.vs, exp.stb,
               exp.act, exp.fs, exp.hr, exp.mn, exp.sec, exp.terr);
    end
  endtask

  // Predict the outputs after the coming edge from the inputs now applied.
  task automatic push();
    obs_t ea, eb;
    if (!rst_n) begin
      c_a = 0; c_b = 0;
      cap_sec = '0; cap_min = '0; cap_hr = '0; cap_err = 1'b0;
    end else begin
      c_a++; c_b++;
    end
    ea = model(CD, 1'b0, c_a);
    eb = model(1, 1'b1, c_b);
    if (rst_n) begin
`ifdef VGA_TIME_LATCH_EN
      if ((c_a % CD) == 0 && ea.x == '0 && ea.y == CW'(VA)) begin
`else
      begin
`endif
        cap_sec = seconds;
        cap_min = minutes;
        cap_hr  = hours;
        cap_err = (seconds > 59) || (minutes > 59) || (hours > 23);
      end
    end
    ea.sec = cap_sec; ea.mn = cap_min; ea.hr = cap_hr; ea.terr = cap_err;
    exp_a.push_back(ea);
    exp_b.push_back(eb);
  endtask

  task automatic step();
    obs_t e;
    push();
    @(negedge clk);
    e = exp_a.pop_front();
    check_obs("main", got_a, e);
    e = exp_b.pop_front();
    check_obs("sweep", got_b, e);
  endtask

  task automatic wait_y(int y);
    int n = 0;
    while (int'(a_y) != y && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("wait_pix_y", 32'(a_y), 32'(y));
  endtask

  task automatic wait_fs();
    int n = 0;
    while (a_fs !== 1'b1 && n < 2 * FRAME) begin
      step();
      n++;
    end
    check("wait_frame_start", 32'(a_fs), 32'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog at %0t: bench did not complete", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs_lo, vs_lo, gap, b_hi, b_run, b_max, b_stb_lo;
    logic [5:0] prev_sec;
    int n;

    tv[0] = '{6'd12, 6'd30, 5'd5,  1'b0};
    tv[1] = '{6'd59, 6'd59, 5'd23, 1'b0};
    tv[2] = '{6'd60, 6'd0,  5'd0,  1'b1};
    tv[3] = '{6'd0,  6'd60, 5'd0,  1'b1};
    tv[4] = '{6'd0,  6'd0,  5'd24, 1'b1};
    tv[5] = '{6'd13, 6'd7,  5'd19, 1'b0};
    tv[6] = '{6'd63, 6'd63, 5'd31, 1'b1};
    tv[7] = '{6'd0,  6'd0,  5'd0,  1'b0};

    // Reset held for 10 clocks.
    rst_n = 1'b0;
    repeat (10) step();
    check("rst_pix_x", 32'(a_x), 32'(HT - 1));
    check("rst_pix_y", 32'(a_y), 32'(VT - 1));
    check("rst_hs", 32'(a_hs), 32'd1);
    check("rst_vs", 32'(a_vs), 32'd1);
    check("rst_active", 32'(a_act), 32'd0);

    // Release: frame_start exactly CD clocks later, at (0,0).
    rst_n = 1'b1;
    for (int k = 1; k <= CD; k++) begin
      step();
      check("fs_after_release", 32'(a_fs), (k == CD) ? 32'd1 : 32'd0);
    end
    check("first_x", 32'(a_x), 32'd0);
    check("first_y", 32'(a_y), 32'd0);
    check("first_active", 32'(a_act), 32'd1);
    step();
    check("fs_one_clk", 32'(a_fs), 32'd0);

    // Time-capture vectors, each held for a full frame.
    foreach (tv[i]) begin
      seconds = tv[i].sec;
      minutes = tv[i].mn;
      hours   = tv[i].hr;
      repeat (FRAME + 2) step();
      check("tv_sec", 32'(a_sec), 32'(tv[i].sec));
      check("tv_min", 32'(a_min), 32'(tv[i].mn));
      check("tv_hr", 32'(a_hr), 32'(tv[i].hr));
      check("tv_err", 32'(a_err), 32'(tv[i].err));
    end

    // One frame of sync/period measurement on both instances.
    wait_fs();
    hs_lo = 0; vs_lo = 0; gap = -1; b_hi = 0; b_run = 0; b_max = 0; b_stb_lo = 0;
    for (int k = 1; k <= FRAME; k++) begin
      step();
      if (!a_hs) hs_lo++;
      if (!a_vs) vs_lo++;
      if (a_fs && gap < 0) gap = k;
      if (!b_stb) b_stb_lo++;
      if (b_hs) begin
        b_hi++;
        b_run++;
        if (b_run > b_max) b_max = b_run;
      end else begin
        b_run = 0;
      end
    end
    check("frame_period", 32'(gap), 32'(FRAME));
    check("hs_low_clks", 32'(hs_lo), 32'(VT * HSY * CD));
    check("vs_low_clks", 32'(vs_lo), 32'(VSY * HT * CD));
    check("sweep_stb_low", 32'(b_stb_lo), 32'd0);
    check("sweep_hs_high", 32'(b_hi), 32'(2 * VT * HSY));
    check("sweep_hs_run", 32'(b_max), 32'(HSY));

    // Seconds 12 -> 13 in the middle of the visible region.
    seconds = 6'd12; minutes = 6'd0; hours = 5'd0;
    repeat (FRAME + 2) step();
    wait_y(2);
    seconds = 6'd13;
`ifdef VGA_TIME_LATCH_EN
    step();
    check("sec_hold", 32'(a_sec), 32'd12);
    n = 0;
    prev_sec = a_sec;
    while (int'(a_y) != VA && n < FRAME) begin
      prev_sec = a_sec;
      step();
      n++;
    end
    check("sec_before_blank", 32'(prev_sec), 32'd12);
    check("sec_at_blank", 32'(a_sec), 32'd13);
`else
    step();
    check("sec_next_clk", 32'(a_sec), 32'd13);
`endif

    // Asynchronous reset in mid-frame, then recovery.
    wait_y(4);
    rst_n = 1'b0;
    #1;
    check("midrst_x", 32'(a_x), 32'(HT - 1));
    check("midrst_y", 32'(a_y), 32'(VT - 1));
    check("midrst_hs", 32'(a_hs), 32'd1);
    check("midrst_vs", 32'(a_vs), 32'd1);
    check("midrst_active", 32'(a_act), 32'd0);
    check("midrst_fs", 32'(a_fs), 32'd0);
    check("midrst_sec", 32'(a_sec), 32'd0);
    check("midrst_err", 32'(a_err), 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    for (int k = 1; k <= CD; k++) begin
      step();
      check("fs_after_midrst", 32'(a_fs), (k == CD) ? 32'd1 : 32'd0);
    end
    repeat (FRAME) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
